blowfish_p_subkey_file: RTL and testbench

- Writable 18x32 Blowfish P-subkey register file: the stateful counterpart of the read-only pi-constant P table.
- On init, computes P[i] = PI[i] XOR key word (i mod key length) into registers.
- Accepts direct subkey writes from the key-expansion engine.
- Streams subkeys to the round datapath: forward order for encryption, reverse order for decryption.

---
 rtl/blowfish_pkg.sv | 47 ++++
 rtl/blowfish_subkey_streamer.sv | 66 ++++++
 rtl/blowfish_p_subkey_file.sv | 108 ++++++++++
 tb/tb_blowfish_p_subkey_file.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/blowfish_pkg.sv
// Shared Blowfish constants, types and helpers for the P-subkey file.
package blowfish_pkg;

  localparam int unsigned BF_NUM_P         = 18;
  localparam int unsigned BF_KEY_WORDS_MAX = 14;
  localparam int unsigned BF_WORD_W        = 32;
  localparam int unsigned BF_KEY_W         = BF_KEY_WORDS_MAX * BF_WORD_W;
  localparam int unsigned BF_IDX_W         = 5;
  localparam int unsigned BF_LEN_W         = 4;

  typedef logic [BF_WORD_W-1:0]                bf_word_t;
  typedef logic [BF_NUM_P-1:0][BF_WORD_W-1:0]  bf_p_file_t;

  // Fractional hex digits of pi, P0..P17.
  localparam bf_word_t BF_PI_P [BF_NUM_P] = '{
    32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344,
    32'ha4093822, 32'h299f31d0, 32'h082efa98, 32'hec4e6c89,
    32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
    32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917,
    32'h9216d5d9, 32'h8979fb1b
  };

  typedef enum logic [1:0] {IDLE, INIT, READY, STREAM} bf_state_t;

  // Clamp a requested key length to 1..14 words.
  function automatic logic [BF_LEN_W-1:0] bf_eff_len(input logic [BF_LEN_W-1:0] len);
    if (len == '0)
      return BF_LEN_W'(1);
    else if (len > BF_LEN_W'(BF_KEY_WORDS_MAX))
      return BF_LEN_W'(BF_KEY_WORDS_MAX);
    else
      return len;
  endfunction

  // Big-endian key word select: word 0 sits in the MSBs.
  function automatic bf_word_t bf_key_word(input logic [BF_KEY_W-1:0] key,
                                           input logic [BF_LEN_W-1:0] k);
    bf_word_t r;
    r = '0;
    for (int w = 0; w < int'(BF_KEY_WORDS_MAX); w++) begin
      if (k == BF_LEN_W'(w))
        r = key[BF_KEY_W-1-BF_WORD_W*w -: BF_WORD_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/blowfish_subkey_streamer.sv
// Presents P subkeys one at a time over a valid/ready handshake, forward or reverse.
module blowfish_subkey_streamer
  import blowfish_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dir,
  input  logic                 abort,
  input  bf_p_file_t           p_file,
  input  logic                 sk_ready,
  output logic                 sk_valid,
  output logic [BF_IDX_W-1:0]  sk_idx,
  output logic [BF_WORD_W-1:0] sk_out,
  output logic                 seq_last,
  output logic                 done_c
);

  localparam logic [BF_IDX_W-1:0] LAST_IDX = BF_IDX_W'(BF_NUM_P - 1);

  logic                dir_q;
  logic [BF_IDX_W-1:0] start_idx;
  logic [BF_IDX_W-1:0] nxt_idx;
  logic                start_last;
  logic                nxt_last;

  // First index of a new stream and the step taken on each handshake.
  always_comb begin
    start_idx  = dir ? LAST_IDX : '0;
    start_last = dir ? (start_idx == '0) : (start_idx == LAST_IDX);
    nxt_idx    = dir_q ? (sk_idx - BF_IDX_W'(1)) : (sk_idx + BF_IDX_W'(1));
    nxt_last   = dir_q ? (nxt_idx == '0) : (nxt_idx == LAST_IDX);
  end

  assign done_c = sk_valid & sk_ready & seq_last;

  // Stream sequencing; sk_out is registered from the file at each index load.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q    <= 1'b0;
      sk_valid <= 1'b0;
      sk_idx   <= '0;
      sk_out   <= '0;
      seq_last <= 1'b0;
    end else if (abort) begin
      sk_valid <= 1'b0;
      seq_last <= 1'b0;
    end else if (start) begin
      dir_q    <= dir;
      sk_valid <= 1'b1;
      sk_idx   <= start_idx;
      sk_out   <= p_file[start_idx];
      seq_last <= start_last;
    end else if (sk_valid && sk_ready) begin
      if (seq_last) begin
        sk_valid <= 1'b0;
        seq_last <= 1'b0;
      end else begin
        sk_idx   <= nxt_idx;
        sk_out   <= p_file[nxt_idx];
        seq_last <= nxt_last;
      end
    end
  end

endmodule

// File: rtl/blowfish_p_subkey_file.sv
// Writable 18x32 Blowfish P-subkey file with key-XOR init, direct writes and streaming.
module blowfish_p_subkey_file
  import blowfish_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_start,
  input  logic [BF_KEY_W-1:0]  key_in,
  input  logic [BF_LEN_W-1:0]  key_len_words,
  output logic                 busy,
  output logic                 init_done,
  output logic                 ready,
  input  logic                 wr_en,
  input  logic [BF_IDX_W-1:0]  wr_idx,
  input  logic [BF_WORD_W-1:0] wr_data,
  input  logic                 seq_start,
  input  logic                 seq_dir,
  output logic                 sk_valid,
  input  logic                 sk_ready,
  output logic [BF_IDX_W-1:0]  sk_idx,
  output logic [BF_WORD_W-1:0] sk_out,
  output logic                 seq_last
);

  localparam logic [BF_IDX_W-1:0] LAST_IDX = BF_IDX_W'(BF_NUM_P - 1);

  bf_state_t             state;
  bf_p_file_t            p_q;
  logic [BF_KEY_W-1:0]   key_q;
  logic [BF_LEN_W-1:0]   len_q;
  logic [BF_IDX_W-1:0]   i_q;
  logic [BF_LEN_W-1:0]   k_q;
  logic                  seq_go_c;
  logic                  abort_c;
  logic                  stream_done_c;

  // A write in the same cycle wins over a stream request; init wins over both.
  assign seq_go_c = (state == READY) & seq_start & ~wr_en & ~init_start;
  assign abort_c  = (state == STREAM) & init_start;

  // Control FSM, register file and init sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p_q       <= '0;
      key_q     <= '0;
      len_q     <= BF_LEN_W'(1);
      i_q       <= '0;
      k_q       <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      ready     <= 1'b0;
    end else begin
      init_done <= 1'b0;
      case (state)
        INIT: begin
          p_q[i_q] <= BF_PI_P[i_q] ^ bf_key_word(key_q, k_q);
          i_q      <= i_q + BF_IDX_W'(1);
          k_q      <= (k_q == len_q - BF_LEN_W'(1)) ? '0 : k_q + BF_LEN_W'(1);
          if (i_q == LAST_IDX) begin
            state     <= READY;
            busy      <= 1'b0;
            init_done <= 1'b1;
            ready     <= 1'b1;
          end
        end
        default: begin
          if (init_start) begin
            state <= INIT;
            key_q <= key_in;
            len_q <= bf_eff_len(key_len_words);
            i_q   <= '0;
            k_q   <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else if (state == READY) begin
            if (wr_en) begin
              if (wr_idx <= LAST_IDX)
                p_q[wr_idx] <= wr_data;
            end else if (seq_start) begin
              state <= STREAM;
              ready <= 1'b0;
            end
          end else if (state == STREAM && stream_done_c) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

  blowfish_subkey_streamer u_streamer (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_go_c),
    .dir      (seq_dir),
    .abort    (abort_c),
    .p_file   (p_q),
    .sk_ready (sk_ready),
    .sk_valid (sk_valid),
    .sk_idx   (sk_idx),
    .sk_out   (sk_out),
    .seq_last (seq_last),
    .done_c   (stream_done_c)
  );

endmodule

// File: tb/tb_blowfish_p_subkey_file.sv
// Directed scoreboard bench for blowfish_p_subkey_file.
module tb_blowfish_p_subkey_file;

  logic         clk = 1'b0;
  logic         rst;
  logic         init_start;
  logic [447:0] key_in;
  logic [3:0]   key_len_words;
  logic         busy, init_done, ready;
  logic         wr_en;
  logic [4:0]   wr_idx;
  logic [31:0]  wr_data;
  logic         seq_start, seq_dir;
  logic         sk_valid, sk_ready;
  logic [4:0]   sk_idx;
  logic [31:0]  sk_out;
  logic         seq_last;

  int errors = 0;
  int checks = 0;

  logic [31:0] pi_tab [18] = '{
    32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344,
    32'ha4093822, 32'h299f31d0, 32'h082efa98, 32'hec4e6c89,
    32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
    32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917,
    32'h9216d5d9, 32'h8979fb1b
  };
  logic [31:0] model [18];
  logic [31:0] cap [18];

  typedef struct { logic [4:0] idx; logic [31:0] data; logic last; } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  blowfish_p_subkey_file dut (
    .clk(clk), .rst(rst), .init_start(init_start), .key_in(key_in),
    .key_len_words(key_len_words), .busy(busy), .init_done(init_done),
    .ready(ready), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .seq_start(seq_start), .seq_dir(seq_dir), .sk_valid(sk_valid),
    .sk_ready(sk_ready), .sk_idx(sk_idx), .sk_out(sk_out), .seq_last(seq_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_init(input logic [447:0] key, input logic [3:0] len);
    int n;
    int l;
    l = (len == 0) ? 1 : ((len > 14) ? 14 : int'(len));
    for (int i = 0; i < 18; i++)
      model[i] = pi_tab[i] ^ key[447 - 32*(i % l) -: 32];
    @(negedge clk);
    init_start = 1'b1; key_in = key; key_len_words = len;
    @(negedge clk);
    init_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("init_busy_cycles", 64'(n), 64'd18);
    chk("init_done_pulse", {62'd0, init_done, ready}, 64'd3);
    @(negedge clk);
    chk("init_done_low", {62'd0, init_done, ready}, 64'd1);
  endtask

  task automatic do_stream(input logic dir, input logic stall);
    int c;
    int hs;
    exp_t e;
    for (int j = 0; j < 18; j++) begin
      e.idx  = dir ? 5'(17 - j) : 5'(j);
      e.data = model[e.idx];
      e.last = (j == 17);
      sb.push_back(e);
    end
    seq_start = 1'b1; seq_dir = dir;
    @(negedge clk);
    seq_start = 1'b0;
    c = 0; hs = 0;
    while (hs < 18 && c < 200) begin
      sk_ready = stall ? c[0] : 1'b1;
      #1;
      if (sk_valid !== 1'b1) begin
        chk("stream_valid", {63'd0, sk_valid}, 64'd1);
      end else begin
        e = sb[0];
        chk("stream_idx", 64'(sk_idx), 64'(e.idx));
        chk("stream_data", 64'(sk_out), 64'(e.data));
        chk("stream_last", {63'd0, seq_last}, {63'd0, e.last});
        if (sk_ready) begin
          cap[e.idx] = sk_out;
          void'(sb.pop_front());
          hs++;
        end
      end
      @(negedge clk);
      c++;
    end
    sk_ready = 1'b0;
    chk("stream_handshakes", 64'(hs), 64'd18);
    chk("stream_end", {62'd0, sk_valid, ready}, 64'd1);
    sb.delete();
  endtask

  initial begin
    logic [447:0] k;
    int n;
    rst = 1'b1; init_start = 1'b0; key_in = '0; key_len_words = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    seq_start = 1'b0; seq_dir = 1'b0; sk_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {busy, init_done, ready, sk_valid, seq_last, sk_idx, sk_out},
        64'd0);

    // seq_start in IDLE is ignored
    seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
    chk("idle_seq_ignored", {62'd0, sk_valid, ready}, 64'd0);

    // Zero key, reverse stream with backpressure
    do_init('0, 4'd1);
    do_stream(1'b1, 1'b1);
    chk("zero_P0", 64'(cap[0]), 64'h243f6a88);
    chk("zero_P8", 64'(cap[8]), 64'h452821e6);
    chk("zero_P17", 64'(cap[17]), 64'h8979fb1b);

    // All-ones word 0
    k = '0; k[447 -: 32] = 32'hffffffff;
    do_init(k, 4'd1);
    do_stream(1'b0, 1'b0);
    chk("ones_P0", 64'(cap[0]), 64'hdbc09577);
    chk("ones_P17", 64'(cap[17]), 64'h768604e4);

    // Two-word key
    k = '0; k[447 -: 32] = 32'h00000001; k[415 -: 32] = 32'h00000002;
    do_init(k, 4'd2);
    do_stream(1'b0, 1'b1);
    chk("two_P0", 64'(cap[0]), 64'h243f6a89);
    chk("two_P1", 64'(cap[1]), 64'h85a308d1);
    chk("two_P2", 64'(cap[2]), 64'h13198a2f);

    // Length 0 clamps to 1, length 15 clamps to 14
    for (int w = 0; w < 14; w++) k[447 - 32*w -: 32] = $urandom;
    do_init(k, 4'd0);
    do_stream(1'b0, 1'b0);
    do_init(k, 4'd15);
    do_stream(1'b1, 1'b0);

    // Direct writes: valid index, out-of-range index, write vs seq_start
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'hdeadbeef;
    model[5] = 32'hdeadbeef;
    @(negedge clk);
    wr_idx = 5'd18; wr_data = 32'h12345678;
    @(negedge clk);
    wr_idx = 5'd9; wr_data = 32'hcafef00d; seq_start = 1'b1; seq_dir = 1'b0;
    model[9] = 32'hcafef00d;
    @(negedge clk);
    wr_en = 1'b0; seq_start = 1'b0;
    chk("write_wins_seq", {62'd0, sk_valid, ready}, 64'd1);
    do_stream(1'b0, 1'b0);
    chk("write_P5", 64'(cap[5]), 64'hdeadbeef);

    // init_start mid-stream aborts the stream
    seq_start = 1'b1; seq_dir = 1'b0;
    @(negedge clk);
    seq_start = 1'b0; sk_ready = 1'b1;
    repeat (3) @(negedge clk);
    sk_ready = 1'b0; init_start = 1'b1; key_in = '0; key_len_words = 4'd1;
    @(negedge clk);
    init_start = 1'b0;
    chk("abort_valid", {62'd0, sk_valid, busy}, 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("abort_busy_cycles", 64'(n), 64'd18);
    chk("abort_ready", {63'd0, ready}, 64'd1);

    // Reset in the middle of INIT
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midinit_reset", {busy, init_done, ready, sk_valid, seq_last, sk_idx, sk_out},
        64'd0);
    seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
    @(negedge clk);
    chk("post_reset_no_stream", {61'd0, sk_valid, ready, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
